// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR vote controller.
// Mode encodings, channel indices and small helpers.
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_DEGRADED = 2'd1,
        MODE_FAILED   = 2'd2
    } mode_t;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;

    localparam int NUM_CH = 3;

    // Number of set bits in a 3-bit channel vector.
    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/tmr_vote_ctrl_maj3.sv
// Bitwise 2-of-3 majority of three equal-width words.
// Purely combinational; used for the all-healthy voting path.
module maj3_vote #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/tmr_vote_ctrl.sv
// TMR vote controller: handshaked majority voter with
// per-channel mismatch counting and NORMAL/DEGRADED/FAILED sequencing.
module tmr_vote_ctrl
    import tmr_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] voted,
    output logic [2:0]       mismatch,
    output logic [2:0]       fault,
    output logic [1:0]       mode,
    input  logic             clr_fault
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ERR_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mode_t                        mode_q;
    logic [2:0]                   fault_q, fault_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                         out_valid_q;
    logic [WIDTH-1:0]             voted_q;
    logic [2:0]                   mismatch_q;

    logic                         accept;
    logic [NUM_CH-1:0][WIDTH-1:0] ch;
    logic [WIDTH-1:0]             maj_w;
    logic [WIDTH-1:0]             vote_w;
    logic [2:0]                   diff_w;
    logic [2:0]                   mismatch_w;
    logic [1:0]                   nfault_d;

    assign ch[CH_A] = a;
    assign ch[CH_B] = b;
    assign ch[CH_C] = c;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    maj3_vote #(.WIDTH(WIDTH)) u_maj (
        .a_i   (a),
        .b_i   (b),
        .c_i   (c),
        .maj_o (maj_w)
    );

    // Pick the voted word using the mode in effect before this sample.
    always_comb begin
        vote_w = maj_w;
        if (mode_q != MODE_NORMAL) begin
            if (!fault_q[CH_A])
                vote_w = a;
            else if (!fault_q[CH_B])
                vote_w = b;
            else if (!fault_q[CH_C])
                vote_w = c;
            else
                vote_w = a;
        end
    end

    // Per-channel disagreement; faulty channels are not reported.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            diff_w[i] = (ch[i] != vote_w);
        mismatch_w = diff_w & ~fault_q;
    end

    // Counter and fault update on accept; a clear overrides it.
    always_comb begin
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (clr_fault) begin
            cnt_d   = '0;
            fault_d = '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!fault_q[i]) begin
                    if (diff_w[i]) begin
                        if (cnt_q[i] != CNT_MAX)
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        if (cnt_d[i] == THRESH_C)
                            fault_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
            end
        end
    end

    assign nfault_d = popcnt3(fault_d);

    // Counter and sticky fault registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            fault_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Mode FSM: advances only, driven by the updated fault count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_NORMAL;
        end else if (clr_fault) begin
            mode_q <= MODE_NORMAL;
        end else begin
            case (mode_q)
                MODE_NORMAL: begin
                    if (nfault_d >= 2'd2)
                        mode_q <= MODE_FAILED;
                    else if (nfault_d == 2'd1)
                        mode_q <= MODE_DEGRADED;
                end
                MODE_DEGRADED: begin
                    if (nfault_d >= 2'd2)
                        mode_q <= MODE_FAILED;
                end
                MODE_FAILED: begin
                    mode_q <= MODE_FAILED;
                end
                default: begin
                    mode_q <= MODE_FAILED;
                end
            endcase
        end
    end

    // Output stage: load on accept, drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            voted_q     <= '0;
            mismatch_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            voted_q     <= vote_w;
            mismatch_q  <= mismatch_w;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign voted     = voted_q;
    assign mismatch  = mismatch_q;
    assign fault     = fault_q;
    assign mode      = mode_q;

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Directed bench for tmr_vote_ctrl (WIDTH=8, ERR_THRESH=3).
// Vector table plus hand-written stall and reset sequences.
module tb_tmr_vote_ctrl;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       clr;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       eov;
        logic [7:0] ev;
        logic [2:0] emm;
        logic [2:0] ef;
        logic [1:0] emd;
    } vec_t;

    localparam int NV = 21;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b, c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] voted;
    logic [2:0] mismatch;
    logic [2:0] fault;
    logic [1:0] mode;
    logic       clr_fault;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    tmr_vote_ctrl #(
        .WIDTH      (8),
        .ERR_THRESH (3),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .voted     (voted),
        .mismatch  (mismatch),
        .fault     (fault),
        .mode      (mode),
        .clr_fault (clr_fault)
    );

    function automatic vec_t mk(
        input logic iv, input logic ordy, input logic clr,
        input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
        input logic eov, input logic [7:0] ev, input logic [2:0] emm,
        input logic [2:0] ef, input logic [1:0] emd);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.clr = clr;
        v.a = va; v.b = vb; v.c = vc;
        v.eov = eov; v.ev = ev; v.emm = emm; v.ef = ef; v.emd = emd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic eov,
                           input logic [7:0] ev, input logic [2:0] emm,
                           input logic [2:0] ef, input logic [1:0] emd);
        chk({tag, " out_valid"}, out_valid, eov);
        chk({tag, " voted"},     voted,     ev);
        chk({tag, " mismatch"},  mismatch,  emm);
        chk({tag, " fault"},     fault,     ef);
        chk({tag, " mode"},      mode,      emd);
    endtask

    initial begin
        // iv ordy clr  a     b     c    | ov voted  mm      fault   mode
        vecs[0]  = mk(1, 1, 0, 8'h5A, 8'h5A, 8'h5A, 1, 8'h5A, 3'b000, 3'b000, 2'd0);
        vecs[1]  = mk(1, 1, 0, 8'hF0, 8'hF0, 8'h0F, 1, 8'hF0, 3'b100, 3'b000, 2'd0);
        vecs[2]  = mk(1, 1, 0, 8'hF0, 8'hF0, 8'h0F, 1, 8'hF0, 3'b100, 3'b000, 2'd0);
        vecs[3]  = mk(1, 1, 0, 8'hF0, 8'hF0, 8'h0F, 1, 8'hF0, 3'b100, 3'b100, 2'd1);
        vecs[4]  = mk(1, 1, 0, 8'h11, 8'h22, 8'h33, 1, 8'h11, 3'b010, 3'b100, 2'd1);
        vecs[5]  = mk(1, 1, 0, 8'h44, 8'h55, 8'h66, 1, 8'h44, 3'b010, 3'b100, 2'd1);
        vecs[6]  = mk(1, 1, 0, 8'h77, 8'h88, 8'h99, 1, 8'h77, 3'b010, 3'b110, 2'd2);
        vecs[7]  = mk(1, 1, 0, 8'h77, 8'h00, 8'h00, 1, 8'h77, 3'b000, 3'b110, 2'd2);
        // clear with accept in FAILED: A chosen, not majority 8'h16
        vecs[8]  = mk(1, 1, 1, 8'h12, 8'h34, 8'h56, 1, 8'h12, 3'b000, 3'b000, 2'd0);
        vecs[9]  = mk(1, 1, 0, 8'hAA, 8'hAA, 8'h55, 1, 8'hAA, 3'b100, 3'b000, 2'd0);
        vecs[10] = mk(1, 1, 0, 8'hAA, 8'hAA, 8'h55, 1, 8'hAA, 3'b100, 3'b000, 2'd0);
        vecs[11] = mk(1, 1, 0, 8'hAA, 8'hAA, 8'hAA, 1, 8'hAA, 3'b000, 3'b000, 2'd0);
        vecs[12] = mk(1, 1, 0, 8'hAA, 8'hAA, 8'h55, 1, 8'hAA, 3'b100, 3'b000, 2'd0);
        vecs[13] = mk(1, 1, 0, 8'hAA, 8'hAA, 8'h55, 1, 8'hAA, 3'b100, 3'b000, 2'd0);
        vecs[14] = mk(1, 1, 0, 8'hAA, 8'hAA, 8'h55, 1, 8'hAA, 3'b100, 3'b100, 2'd1);
        // clear without accept: valid drops, word and mismatch hold
        vecs[15] = mk(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 8'hAA, 3'b100, 3'b000, 2'd0);
        // A and B fault on the same sample: NORMAL -> FAILED
        vecs[16] = mk(1, 1, 0, 8'h01, 8'h02, 8'h03, 1, 8'h03, 3'b011, 3'b000, 2'd0);
        vecs[17] = mk(1, 1, 0, 8'h01, 8'h02, 8'h03, 1, 8'h03, 3'b011, 3'b000, 2'd0);
        vecs[18] = mk(1, 1, 0, 8'h01, 8'h02, 8'h03, 1, 8'h03, 3'b011, 3'b011, 2'd2);
        vecs[19] = mk(1, 1, 0, 8'h01, 8'h02, 8'h09, 1, 8'h09, 3'b000, 3'b011, 2'd2);
        vecs[20] = mk(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 8'h09, 3'b000, 3'b000, 2'd0);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_fault = 1'b0;
        a = '0; b = '0; c = '0;

        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 8'h00, 3'b000, 3'b000, 2'd0);
        chk("reset in_ready", in_ready, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            clr_fault = vecs[i].clr;
            a = vecs[i].a;
            b = vecs[i].b;
            c = vecs[i].c;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].eov, vecs[i].ev,
                    vecs[i].emm, vecs[i].ef, vecs[i].emd);
        end

        // Stall: bring C to one below threshold, then hold off the consumer.
        clr_fault = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = 8'h11; b = 8'h11; c = 8'h22;
        @(negedge clk);
        @(negedge clk);
        chk_out("prime", 1'b1, 8'h11, 3'b100, 3'b000, 2'd0);

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d in_ready", k), in_ready, 1'b0);
            @(negedge clk);
            chk_out($sformatf("stall%0d", k), 1'b1, 8'h11, 3'b100,
                    3'b000, 2'd0);
        end

        out_ready = 1'b1;
        a = 8'h33; b = 8'h33; c = 8'h33;
        #1;
        chk("release in_ready", in_ready, 1'b1);
        @(negedge clk);
        chk_out("release", 1'b1, 8'h33, 3'b000, 3'b000, 2'd0);

        // Reset mid-transfer drops the pending word.
        out_ready = 1'b0;
        a = 8'h5C; b = 8'h5C; c = 8'h5C;
        @(negedge clk);
        chk("pending voted", voted, 8'h33);
        rst = 1'b1;
        #1;
        chk_out("midrst", 1'b0, 8'h00, 3'b000, 3'b000, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post-rst in_ready", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmr_vote_ctrl.md
Name: tmr_vote_ctrl

Overview:
Controller wrapping a bitwise majority voter for triple-modular-redundant channels A/B/C. Accepts samples over a valid/ready handshake and registers the voted word. Tracks consecutive per-channel disagreements, declares a channel faulty at a threshold, and sequences the voting mode NORMAL -> DEGRADED -> FAILED. Sits between three redundant producers and a single downstream consumer.

Parameters:
WIDTH, 8, data width of each channel and the voted output
ERR_THRESH, 4, consecutive mismatching accepted samples before a channel is marked faulty (range 1..2^CNT_W-1)
CNT_W, 4, width of each per-channel mismatch counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  A/B/C sample present
in_ready  output  1  block can accept a sample
a  input  WIDTH  channel A
b  input  WIDTH  channel B
c  input  WIDTH  channel C
out_valid  output  1  voted word valid
out_ready  input  1  consumer accepts the voted word
voted  output  WIDTH  registered voted word
mismatch  output  3  registered; bit i set if channel i (0=A,1=B,2=C) differed from the voted word on the last accepted sample
fault  output  3  sticky per-channel fault flags
mode  output  2  0=NORMAL, 1=DEGRADED, 2=FAILED
clr_fault  input  1  synchronous clear of faults, counters and mode

Behaviour:
- Reset (async, rst=1): out_valid=0, voted=0, mismatch=0, fault=0, mode=NORMAL, all counters=0. in_ready=1 after reset.
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready. On accept, voted/mismatch load next cycle and out_valid=1. Latency 1 cycle. Full throughput when out_ready=1.
- out_valid clears on out_ready & !accept. voted holds while out_valid & !out_ready.
- Voting uses the mode in effect in the accept cycle, i.e. before that sample's fault update:
  - NORMAL: voted = (a&b)|(a&c)|(b&c).
  - DEGRADED: voted = the lower-indexed healthy channel. mismatch still marks the healthy channel that differs.
  - FAILED: voted = the lowest-indexed healthy channel, or a if all three are faulty.
- Counters, on accept, for each non-faulty channel i:
  - if channel i != voted, cnt_i = cnt_i + 1, saturating at 2^CNT_W-1;
  - otherwise cnt_i = 0.
  - When the incremented value reaches ERR_THRESH, fault[i] sets in the same update and cnt_i freezes.
  - Faulty channels do not count.
- FSM, evaluated on the new fault vector:
  - popcount 0 -> NORMAL; 1 -> DEGRADED; >=2 -> FAILED.
  - Transitions only advance. Leaving FAILED or DEGRADED happens only via clr_fault or rst.
  - Two channels faulting on the same sample go NORMAL -> FAILED directly.
- clr_fault: next cycle fault=0, counters=0, mode=NORMAL.
  - If it coincides with an accept, the sample is still voted with the pre-clear mode and its output is produced, but its counter/fault update is discarded (clear wins).
  - clr_fault does not affect out_valid or voted.
- Stall: while out_valid & !out_ready, no accept occurs and counters are unchanged, even if in_valid=1.
- rst asserted mid-transfer drops any pending voted word. The consumer must not see it.

Decomposition:
- Shared package tmr_pkg holds:
  - mode encodings MODE_NORMAL/MODE_DEGRADED/MODE_FAILED;
  - channel index constants CH_A/CH_B/CH_C;
  - mode_t typedef.
- One natural sub-module, maj3_vote (WIDTH-parameterised combinational bitwise majority), is instantiated for the NORMAL path.
- Counter, FSM and handshake logic stay in tmr_vote_ctrl.

Test Plan:
- WIDTH=8, ERR_THRESH=3. Reset, then a=b=c=8'h5A, in_valid=1, out_ready=1 -> next cycle out_valid=1, voted=8'h5A, mismatch=3'b000, mode=0.
- a=8'hF0, b=8'hF0, c=8'h0F for 3 consecutive accepts -> voted=8'hF0 each cycle, mismatch=3'b100. After the 3rd accept fault=3'b100 and mode=1. Next sample a=8'h11, b=8'h22, c=8'h33 -> voted=8'h11 (A), mismatch=3'b010.
- In DEGRADED with C faulty, B differs for 3 accepts -> fault=3'b110, mode=2. Next sample a=8'h77 -> voted=8'h77.
- Mismatch on C twice, then one agreeing sample, then twice more -> no fault (count reset), mode stays 0.
- Stall: out_ready=0 with out_valid=1 for 5 cycles, in_valid=1 -> in_ready=0, voted stable, counters unchanged. Release -> next sample accepted the same cycle.
- Assert clr_fault with an accept while mode=2 -> the sample is voted with FAILED rules. Next cycle fault=0, mode=0, counters=0.
